// File: rtl/digit_match_pkg.sv
// Shared types and constants for the digit match sequencer: image geometry,
// score width, controller states and the shared absolute-difference helper.
package digit_match_pkg;

  localparam int NUM_DIGITS = 10;
  localparam int IMG_W      = 11;
  localparam int NPIX       = 121;
  localparam int PIX_W      = 8;
  localparam int SCORE_W    = 16;

  localparam logic [6:0] LAST_ADDR  = 7'(NPIX - 1);
  localparam logic [3:0] LAST_DIGIT = 4'(NUM_DIGITS - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RUN  = 3'd1,
    S_LAST = 3'd2,
    S_CMP  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  typedef logic [PIX_W-1:0]   pix_t;
  typedef logic [SCORE_W-1:0] score_t;

  // Unsigned magnitude of the difference; never negative.
  function automatic pix_t abs_diff(input pix_t a, input pix_t b);
    pix_t d;
    if (a >= b) begin
      d = a - b;
    end else begin
      d = b - a;
    end
    return d;
  endfunction

endpackage

// File: rtl/digit_match_sequencer_if.sv
// Handshake and pixel-port bundle between the controller, the image buffer
// and the consumer of the recognised digit.
interface digit_match_sequencer_if;
  import digit_match_pkg::*;

  logic       start;
  logic [6:0] pix_addr;
  logic       pix_rd;
  pix_t       pix_data;
  logic       busy;
  logic       done;
  logic [3:0] digit_out;
  score_t     score_out;

  modport master (
    output start, pix_data,
    input  pix_addr, pix_rd, busy, done, digit_out, score_out
  );

  modport slave (
    input  start, pix_data,
    output pix_addr, pix_rd, busy, done, digit_out, score_out
  );

endinterface

// File: rtl/digit_match_sequencer_rom.sv
// Stored digit templates: seven-segment style glyphs on the 11x11 grid,
// ink pixels at a high level over a uniform dark background.
module digit_template_rom
  import digit_match_pkg::*;
(
  input  logic [3:0] digit,
  input  logic [6:0] addr,
  output pix_t       value
);

  localparam pix_t INK_LEVEL = 8'd224;
  localparam pix_t BG_LEVEL  = 8'd16;

  logic [6:0] row_s;
  logic [6:0] col_s;
  logic [6:0] mask_s;
  logic [6:0] hit_s;

  // Decode address into segment hits and look up the digit's segment mask.
  always_comb begin
    row_s = addr / 7'(IMG_W);
    col_s = addr - (row_s * 7'(IMG_W));
    hit_s[0] = (row_s == 7'd1) && (col_s >= 7'd2) && (col_s <= 7'd8);
    hit_s[1] = (col_s == 7'd8) && (row_s >= 7'd1) && (row_s <= 7'd5);
    hit_s[2] = (col_s == 7'd8) && (row_s >= 7'd5) && (row_s <= 7'd9);
    hit_s[3] = (row_s == 7'd9) && (col_s >= 7'd2) && (col_s <= 7'd8);
    hit_s[4] = (col_s == 7'd2) && (row_s >= 7'd5) && (row_s <= 7'd9);
    hit_s[5] = (col_s == 7'd2) && (row_s >= 7'd1) && (row_s <= 7'd5);
    hit_s[6] = (row_s == 7'd5) && (col_s >= 7'd2) && (col_s <= 7'd8);
    case (digit)
      4'd0:    mask_s = 7'h3F;
      4'd1:    mask_s = 7'h06;
      4'd2:    mask_s = 7'h5B;
      4'd3:    mask_s = 7'h4F;
      4'd4:    mask_s = 7'h66;
      4'd5:    mask_s = 7'h6D;
      4'd6:    mask_s = 7'h7D;
      4'd7:    mask_s = 7'h07;
      4'd8:    mask_s = 7'h7F;
      4'd9:    mask_s = 7'h6F;
      default: mask_s = 7'h00;
    endcase
    if ((mask_s & hit_s) != 7'h00) begin
      value = INK_LEVEL;
    end else begin
      value = BG_LEVEL;
    end
  end

endmodule

// File: rtl/digit_match_sequencer.sv
// Sequential template matcher: streams the image once per template through a
// single abs-difference unit and keeps the lowest-scoring digit.
module digit_match_sequencer
  import digit_match_pkg::*;
(
  input  logic                    iCLK,
  input  logic                    iRST_N,
  digit_match_sequencer_if.slave  bus
);

  state_t     state_r;
  logic [3:0] digit_r;
  logic [6:0] addr_r;
  score_t     acc_r;
  score_t     best_r;
  logic [3:0] best_digit_r;
  logic [6:0] pix_addr_r;
  logic       pix_rd_r;
  logic       busy_r;
  logic       done_r;
  logic [3:0] digit_out_r;
  score_t     score_out_r;

  logic [6:0] tmpl_addr_s;
  pix_t       tmpl_s;
  pix_t       diff_s;
  score_t     acc_sum_s;
  score_t     best_next_s;
  logic [3:0] best_digit_next_s;

  digit_template_rom u_rom (
    .digit (digit_r),
    .addr  (tmpl_addr_s),
    .value (tmpl_s)
  );

  // Data returning now belongs to the address issued one cycle earlier.
  always_comb begin
    if (state_r == S_LAST) begin
      tmpl_addr_s = addr_r;
    end else begin
      tmpl_addr_s = addr_r - 7'd1;
    end
    diff_s    = abs_diff(bus.pix_data, tmpl_s);
    acc_sum_s = acc_r + score_t'(diff_s);
    if (acc_r < best_r) begin
      best_next_s       = acc_r;
      best_digit_next_s = digit_r;
    end else begin
      best_next_s       = best_r;
      best_digit_next_s = best_digit_r;
    end
  end

  // Controller FSM with counters, accumulator and registered outputs.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_r      <= S_IDLE;
      digit_r      <= 4'd0;
      addr_r       <= 7'd0;
      acc_r        <= '0;
      best_r       <= '1;
      best_digit_r <= 4'd0;
      pix_addr_r   <= 7'd0;
      pix_rd_r     <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      digit_out_r  <= 4'd0;
      score_out_r  <= '0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (bus.start) begin
            digit_r      <= 4'd0;
            addr_r       <= 7'd0;
            acc_r        <= '0;
            best_r       <= '1;
            best_digit_r <= 4'd0;
            pix_addr_r   <= 7'd0;
            pix_rd_r     <= 1'b1;
            busy_r       <= 1'b1;
            state_r      <= S_RUN;
          end
        end
        S_RUN: begin
          if (addr_r != 7'd0) begin
            acc_r <= acc_sum_s;
          end
          if (addr_r == LAST_ADDR) begin
            pix_rd_r <= 1'b0;
            state_r  <= S_LAST;
          end else begin
            addr_r     <= addr_r + 7'd1;
            pix_addr_r <= addr_r + 7'd1;
          end
        end
        S_LAST: begin
          acc_r   <= acc_sum_s;
          state_r <= S_CMP;
        end
        S_CMP: begin
          best_r       <= best_next_s;
          best_digit_r <= best_digit_next_s;
          if (digit_r == LAST_DIGIT) begin
            digit_out_r <= best_digit_next_s;
            score_out_r <= best_next_s;
            done_r      <= 1'b1;
            busy_r      <= 1'b0;
            state_r     <= S_DONE;
          end else begin
            digit_r    <= digit_r + 4'd1;
            addr_r     <= 7'd0;
            acc_r      <= '0;
            pix_addr_r <= 7'd0;
            pix_rd_r   <= 1'b1;
            state_r    <= S_RUN;
          end
        end
        S_DONE: begin
          done_r  <= 1'b0;
          state_r <= S_IDLE;
        end
        default: begin
          pix_rd_r <= 1'b0;
          busy_r   <= 1'b0;
          done_r   <= 1'b0;
          state_r  <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.pix_addr  = pix_addr_r;
  assign bus.pix_rd    = pix_rd_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.digit_out = digit_out_r;
  assign bus.score_out = score_out_r;

endmodule

// File: tb/tb_digit_match_sequencer.sv
// Randomised bench for digit_match_sequencer: a one-cycle-latency image buffer
// model plus an argmin-over-templates reference computed from whole images.
module tb_digit_match_sequencer;
  import digit_match_pkg::*;

  localparam int DONE_CYCLE = 1231;

  logic iCLK = 1'b0;
  logic iRST_N;
  int   checks = 0;
  int   errors = 0;
  int   img_m  [NPIX];
  int   tmpl_m [NUM_DIGITS][NPIX];
  int   last_d = 0;
  int   last_s = 0;
  string segs [NUM_DIGITS] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg",
                               "acdfg", "acdefg", "abc", "abcdefg", "abcdfg"};

  digit_match_sequencer_if bus ();

  digit_match_sequencer dut (
    .iCLK   (iCLK),
    .iRST_N (iRST_N),
    .bus    (bus)
  );

  always #5 iCLK = ~iCLK;

  // Image buffer: one-cycle read latency.
  always @(posedge iCLK) begin
    if (bus.pix_rd) bus.pix_data <= pix_t'(img_m[bus.pix_addr]);
  end

  task automatic check_val(input string tag, input int obs, input int exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic build_templates();
    byte ch;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      for (int p = 0; p < NPIX; p++) tmpl_m[d][p] = 16;
      for (int i = 0; i < segs[d].len(); i++) begin
        ch = segs[d][i];
        for (int j = 0; j < 7; j++) begin
          case (ch)
            "a": tmpl_m[d][1 * 11 + 2 + j] = 224;
            "g": tmpl_m[d][5 * 11 + 2 + j] = 224;
            "d": tmpl_m[d][9 * 11 + 2 + j] = 224;
            default: ;
          endcase
        end
        for (int r = 0; r < 5; r++) begin
          case (ch)
            "f": tmpl_m[d][(1 + r) * 11 + 2] = 224;
            "b": tmpl_m[d][(1 + r) * 11 + 8] = 224;
            "e": tmpl_m[d][(5 + r) * 11 + 2] = 224;
            "c": tmpl_m[d][(5 + r) * 11 + 8] = 224;
            default: ;
          endcase
        end
      end
    end
  endtask

  task automatic model(output int d_o, output int s_o);
    int best, s, diff;
    best = 1 << 30;
    d_o  = 0;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      s = 0;
      for (int p = 0; p < NPIX; p++) begin
        diff = img_m[p] - tmpl_m[d][p];
        s += (diff < 0) ? -diff : diff;
      end
      if (s < best) begin
        best = s;
        d_o  = d;
      end
    end
    s_o = best;
  endtask

  task automatic load_template(input int d);
    for (int p = 0; p < NPIX; p++) img_m[p] = tmpl_m[d][p];
  endtask

  // One full classification, checked cycle by cycle against the timing rules.
  task automatic run_and_check(input string tag, input bit hold, input bit pulses);
    int exp_d, exp_s, pos;
    int busy_err, trace_err, hold_err, done_cnt, done_cyc, dig_obs, sc_obs;
    bit exp_rd;
    model(exp_d, exp_s);
    busy_err = 0; trace_err = 0; hold_err = 0; done_cnt = 0; done_cyc = -1;
    dig_obs = -1; sc_obs = -1;
    @(negedge iCLK);
    bus.start = 1'b1;
    @(posedge iCLK);
    for (int k = 1; k <= DONE_CYCLE; k++) begin
      #1;
      if (!hold) bus.start = (pulses && (k == 300 || k == 900)) ? 1'b1 : 1'b0;
      pos    = (k - 1) % 123;
      exp_rd = (k < DONE_CYCLE) && (pos < NPIX);
      if (bus.busy !== (k < DONE_CYCLE)) busy_err++;
      if (bus.pix_rd !== exp_rd) trace_err++;
      if (exp_rd && (int'(bus.pix_addr) != pos)) trace_err++;
      if (bus.done === 1'b1) begin
        done_cnt++;
        done_cyc = k;
      end
      if (k < DONE_CYCLE) begin
        if ((int'(bus.digit_out) != last_d) || (int'(bus.score_out) != last_s)) hold_err++;
      end else begin
        dig_obs = int'(bus.digit_out);
        sc_obs  = int'(bus.score_out);
      end
      @(posedge iCLK);
    end
    check_val({tag, " busy"}, busy_err, 0);
    check_val({tag, " pix trace"}, trace_err, 0);
    check_val({tag, " result hold"}, hold_err, 0);
    check_val({tag, " done count"}, done_cnt, 1);
    check_val({tag, " done cycle"}, done_cyc, DONE_CYCLE);
    check_val({tag, " digit"}, dig_obs, exp_d);
    check_val({tag, " score"}, sc_obs, exp_s);
    last_d = exp_d;
    last_s = exp_s;
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, " busy"}, int'(bus.busy), 0);
    check_val({tag, " done"}, int'(bus.done), 0);
    check_val({tag, " pix_rd"}, int'(bus.pix_rd), 0);
    check_val({tag, " pix_addr"}, int'(bus.pix_addr), 0);
    check_val({tag, " digit_out"}, int'(bus.digit_out), 0);
    check_val({tag, " score_out"}, int'(bus.score_out), 0);
  endtask

  initial begin
    int v, base;
    iRST_N    = 1'b0;
    bus.start = 1'b0;
    build_templates();
    for (int p = 0; p < NPIX; p++) img_m[p] = 0;
    repeat (3) @(posedge iCLK);
    #1;
    check_all_zero("reset");
    @(negedge iCLK);
    iRST_N = 1'b1;
    repeat (2) @(posedge iCLK);

    load_template(1);
    run_and_check("tmpl1", 1'b0, 1'b0);
    check_val("tmpl1 exact score", last_s, 0);

    load_template(7);
    img_m[60] = img_m[60] + 5;
    run_and_check("tmpl7+5", 1'b0, 1'b0);

    for (int p = 0; p < NPIX; p++) img_m[p] = 255;
    run_and_check("all255", 1'b0, 1'b0);
    check_val("all255 score bound", int'(int'(bus.score_out) <= 30855), 1);

    // Digits 0 and 8 differ only in the middle bar; a mid-level bar ties them.
    load_template(0);
    for (int c = 3; c <= 7; c++) img_m[55 + c] = 120;
    run_and_check("tie", 1'b0, 1'b0);

    for (int p = 0; p < NPIX; p++) img_m[p] = int'($urandom_range(0, 255));
    run_and_check("pulses", 1'b0, 1'b1);

    run_and_check("held1", 1'b1, 1'b0);
    run_and_check("held2", 1'b1, 1'b0);
    #1;
    bus.start = 1'b0;
    repeat (2) @(posedge iCLK);

    @(negedge iCLK);
    bus.start = 1'b1;
    @(posedge iCLK);
    #1;
    bus.start = 1'b0;
    repeat (499) @(posedge iCLK);
    #3;
    iRST_N = 1'b0;
    #1;
    check_all_zero("midrun reset");
    @(negedge iCLK);
    iRST_N = 1'b1;
    last_d = 0;
    last_s = 0;
    load_template(4);
    img_m[17] = 0;
    run_and_check("after reset", 1'b0, 1'b0);

    for (int r = 0; r < 20; r++) begin
      base = int'($urandom_range(0, 2));
      if (base == 0) begin
        for (int p = 0; p < NPIX; p++) img_m[p] = int'($urandom_range(0, 255));
      end else begin
        load_template(int'($urandom_range(0, NUM_DIGITS - 1)));
        for (int p = 0; p < NPIX; p++) begin
          v = img_m[p] + int'($urandom_range(0, 80)) - 40;
          img_m[p] = (v < 0) ? 0 : ((v > 255) ? 255 : v);
        end
      end
      run_and_check($sformatf("rand%0d", r), 1'b0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
